// File: rtl/handshake_receiver_fifo.sv
// Receiving end of an 8-bit valid/ready link: first-word-fall-through FIFO feeding a local consumer.
// Optional statistics outputs (rx_count, ovf_seen) are enabled by defining HS_RX_STATS_EN.
module handshake_receiver_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
`ifdef HS_RX_STATS_EN
  output logic [15:0]           rx_count,
  output logic [0:0]            ovf_seen,
`endif
  output logic [ADDR_WIDTH:0]   level
);

  localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = DEPTH;
  localparam logic [ADDR_WIDTH:0]   LEVEL_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = 1;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   level_r;
  logic [ADDR_WIDTH:0]   level_nx_s;
  logic                  out_valid_r;
  logic                  full_r;
  logic                  rdy_en_r;
  logic                  push_s;
  logic                  pop_s;

  // Handshake qualification; ready depends only on registered state.
  always_comb begin
    in_ready = rdy_en_r & ~full_r;
    push_s   = in_valid & in_ready;
    pop_s    = out_valid_r & out_ready;
  end

  // Occupancy next-state: simultaneous push and pop leave the level unchanged.
  always_comb begin
    level_nx_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nx_s = level_r + LEVEL_ONE;
      2'b01:   level_nx_s = level_r - LEVEL_ONE;
      default: level_nx_s = level_r;
    endcase
  end

  // Pointer, level and status registers; rdy_en_r holds ready low until the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      out_valid_r <= 1'b0;
      full_r      <= 1'b0;
      rdy_en_r    <= 1'b0;
    end else begin
      rdy_en_r    <= 1'b1;
      level_r     <= level_nx_s;
      out_valid_r <= (level_nx_s != '0);
      full_r      <= (level_nx_s == FULL_LEVEL);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Storage array; cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = mem_r[rd_ptr_r];
  assign level     = level_r;

`ifdef HS_RX_STATS_EN
  logic [15:0] rx_count_r;
  logic        ovf_seen_r;

  // Accepted-push counter (wraps) and sticky flag for words offered while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count_r <= 16'h0000;
      ovf_seen_r <= 1'b0;
    end else begin
      if (push_s) begin
        rx_count_r <= rx_count_r + 16'h0001;
      end else begin
        rx_count_r <= rx_count_r;
      end
      if (in_valid && full_r) begin
        ovf_seen_r <= 1'b1;
      end else begin
        ovf_seen_r <= ovf_seen_r;
      end
    end
  end

  assign rx_count    = rx_count_r;
  assign ovf_seen[0] = ovf_seen_r;
`endif

endmodule

// File: tb/tb_handshake_receiver_fifo.sv
// Directed bench for handshake_receiver_fifo: vector table for reset/single/fill cases,
// hand-written sequences for streaming and stall-then-reset.
module tb_handshake_receiver_fifo;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [2:0]  level;
`ifdef HS_RX_STATS_EN
  logic [15:0] rx_count;
  logic [0:0]  ovf_seen;
`endif

  int checks = 0;
  int errors = 0;

  handshake_receiver_fifo #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
`ifdef HS_RX_STATS_EN
    .rx_count  (rx_count),
    .ovf_seen  (ovf_seen),
`endif
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [7:0]  din;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        chk_od;
    logic [2:0]  e_lvl;
    logic [15:0] e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_stats(input string tag, input logic [15:0] e_cnt, input logic e_ovf);
`ifdef HS_RX_STATS_EN
    check({tag, " rx_count"}, {16'h0000, rx_count}, {16'h0000, e_cnt});
    check({tag, " ovf_seen"}, {31'h0, ovf_seen}, {31'h0, e_ovf});
`else
    if (tag.len() < 0) $display("%0h %0h", e_cnt, e_ovf);
`endif
  endtask

  task automatic step(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    //          rst   iv    din    ordy  e_ir  e_ov  e_od   chk   lvl   cnt       ovf
    vecs[0]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 16'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 16'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 16'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 16'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 3'd1, 16'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 16'd1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 16'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 16'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 3'd1, 16'd1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 3'd2, 16'd2, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 3'd3, 16'd3, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 3'd4, 16'd4, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 3'd4, 16'd4, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 3'd3, 16'd4, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 3'd4, 16'd5, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 3'd3, 16'd5, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 3'd2, 16'd5, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 3'd1, 16'd5, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 16'd5, 1'b1};

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      check($sformatf("vec%0d in_ready", i), {31'h0, in_ready}, {31'h0, vecs[i].e_ir});
      check($sformatf("vec%0d out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].e_ov});
      check($sformatf("vec%0d level", i), {29'h0, level}, {29'h0, vecs[i].e_lvl});
      if (vecs[i].chk_od) begin
        check($sformatf("vec%0d out_data", i), {24'h0, out_data}, {24'h0, vecs[i].e_od});
      end
      check_stats($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_ovf);
    end

    // Streaming: push and pop every cycle; level pinned at 1, each word appears right after its push.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b1);
      check($sformatf("stream%0d level", i), {29'h0, level}, 32'd1);
      check($sformatf("stream%0d out_valid", i), {31'h0, out_valid}, 32'd1);
      check($sformatf("stream%0d out_data", i), {24'h0, out_data}, i);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("stream_end level", {29'h0, level}, 32'd0);
    check("stream_end out_valid", {31'h0, out_valid}, 32'd0);
    check_stats("stream_end", 16'd21, 1'b1);

    // Stall: three words buffered, consumer not ready for five cycles.
    step(1'b0, 1'b1, 8'hC1, 1'b0);
    step(1'b0, 1'b1, 8'hC2, 1'b0);
    step(1'b0, 1'b1, 8'hC3, 1'b0);
    check("fill3 level", {29'h0, level}, 32'd3);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check($sformatf("stall%0d out_data", i), {24'h0, out_data}, 32'hC1);
      check($sformatf("stall%0d out_valid", i), {31'h0, out_valid}, 32'd1);
      check($sformatf("stall%0d level", i), {29'h0, level}, 32'd3);
    end
    check_stats("stall", 16'd24, 1'b1);

    // Asynchronous reset mid-stall: outputs clear without waiting for a clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst level", {29'h0, level}, 32'd0);
    check("async_rst out_valid", {31'h0, out_valid}, 32'd0);
    check("async_rst in_ready", {31'h0, in_ready}, 32'd0);
    check_stats("async_rst", 16'd0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("post_rst in_ready", {31'h0, in_ready}, 32'd1);
    check("post_rst level", {29'h0, level}, 32'd0);
    step(1'b0, 1'b1, 8'h42, 1'b0);
    check("post_rst push out_data", {24'h0, out_data}, 32'h42);
    check("post_rst push level", {29'h0, level}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
